sbox_sched: RTL and testbench
=============================

SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 SHALL have parameter: LANES, default 4, number of byte S-box lookups per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port: st_req_valid  in  1  cipher-state SubBytes request.
REQ-005 SHALL have port: st_req_ready  out  1  state request accepted when valid and ready are both high.
REQ-006 SHALL have port: st_inv  in  1  1 = InvSubBytes, 0 = SubBytes; sampled at accept.
REQ-007 SHALL have port: st_in  in  128  state; byte i = st_in[8i+7:8i].
REQ-008 SHALL have port: st_out_valid  out  1  state result available.
REQ-009 SHALL have port: st_out_ready  in  1  consumer takes the state result.
REQ-010 SHALL have port: st_out  out  128  substituted state, same byte order as st_in.
REQ-011 SHALL have port: kw_req_valid  in  1  key-expansion SubWord request (forward S-box only).
REQ-012 SHALL have port: kw_req_ready  out  1  word request accepted when valid and ready are both high.
REQ-013 SHALL have port: kw_in  in  32  word; byte i = kw_in[8i+7:8i].
REQ-014 SHALL have port: kw_out_valid  out  1  word result available.
REQ-015 SHALL have port: kw_out_ready  in  1  consumer takes the word result.
REQ-016 SHALL have port: kw_out  out  32  substituted word.

Function
REQ-017 SHALL share one LANES-wide S-box unit between the state and word requesters; only one request is in flight at a time.
REQ-018 SHALL implement the FSM states IDLE, ST_BUSY, KW_BUSY, ST_DONE and KW_DONE.
REQ-019 In IDLE, SHALL drive ready high only to the granted requester; ready is low in every other state.
REQ-020 Grant rule: if only one requester is valid, that requester is granted; if both are valid, the holder of the round-robin pointer is granted.
REQ-021 The round-robin pointer SHALL move to the other requester after each grant, including when the other requester was idle.
REQ-022 At accept, SHALL register the input data and st_inv, clear the pass counter, and go to ST_BUSY or KW_BUSY.
REQ-023 Input changes after accept SHALL have no effect on the in-flight request.
REQ-024 In BUSY, each cycle SHALL process pass p, covering bytes p*LANES to p*LANES+LANES-1, and write the results into the output register.
REQ-025 Pass counts: state needs 16/LANES passes, word needs 4/LANES passes; the counter wraps to 0 on the last pass and the FSM moves to DONE.
REQ-026 Latency: out_valid SHALL rise P cycles after the accept cycle, where P is the pass count (LANES=4: state 4 cycles, word 1 cycle).
REQ-027 In DONE, out_valid SHALL stay high and out SHALL stay stable until out_ready is high; on that handshake the FSM returns to IDLE.
REQ-028 The earliest next accept is the cycle after the output handshake; there is no same-cycle output-and-accept.
REQ-029 Outputs SHALL be registered; st_out and kw_out hold their last result after the handshake.
REQ-030 out_ready asserted while the matching out_valid is low SHALL be ignored.

Reset
REQ-031 When rst is high, the FSM SHALL go to IDLE, the counter to 0 and the pointer to the kw requester.
REQ-032 When rst is high, st_out_valid, kw_out_valid, st_out and kw_out SHALL be 0; st_req_ready and kw_req_ready SHALL be 0 in the reset cycle.
REQ-033 Reset mid-operation (BUSY or DONE) SHALL discard the request with no result produced.

Structure
REQ-034 A shared package aes_pkg SHALL hold the forward and inverse S-box tables, the FSM state enum, and the constants STATE_BYTES=16 and WORD_BYTES=4.
REQ-035 A sub-module sbox_lut SHALL do a combinational 8-bit lookup with a forward/inverse select; it is instantiated LANES times.

Verification
REQ-036 State request st_in=0, st_inv=0 -> st_out_valid rises 4 cycles after accept (LANES=4) with st_out = all bytes 0x63.
REQ-037 kw_in=32'hcf4f3c09 -> kw_out_valid rises 1 cycle after accept with kw_out=32'h8a84eb01.
REQ-038 State request with all bytes 0x63 and st_inv=1 -> st_out = 0; then byte0=0x53, other bytes 0x00, st_inv=0 -> st_out byte0=0xed, other bytes 0x63.
REQ-039 Both requesters valid from reset -> kw is granted first, then st; with both held valid, grants alternate kw, st, kw, st.
REQ-040 st_out_ready held low for 10 cycles -> st_out_valid and st_out stay stable and kw_req_ready stays 0 even though kw_req_valid is high.
REQ-041 rst pulsed in pass 2 of a state request -> no st_out_valid, all outputs 0, and the next request completes normally; repeat with LANES=1 and LANES=2 (state 16 or 8 cycles, word 4 or 2 cycles).

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES S-box tables, scheduler state enum and byte-count constants
package aes_pkg;

   localparam int STATE_BYTES = 16;
   localparam int WORD_BYTES  = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ST_BUSY = 3'd1,
      KW_BUSY = 3'd2,
      ST_DONE = 3'd3,
      KW_DONE = 3'd4
   } sched_state_e;

   // Entry 0x00 sits in the top byte, so entry x lives at bit (255-x)*8.
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] r;
      r = 8'hff - x;
      return SBOX_FWD[{r, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'hff - x;
      return SBOX_INV[{r, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/sbox_lut.sv
// rtl/sbox_lut.sv - combinational single-byte forward/inverse S-box lookup
module sbox_lut
   import aes_pkg::*;
(
   input  logic [7:0] din,
   input  logic       inv,
   output logic [7:0] dout
);

   assign dout = inv ? sbox_inv(din) : sbox_fwd(din);

endmodule

// File: rtl/sbox_sched.sv
// rtl/sbox_sched.sv - shares one LANES-wide S-box between SubBytes and SubWord requesters
module sbox_sched
   import aes_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req_valid,
   output logic         st_req_ready,
   input  logic         st_inv,
   input  logic [127:0] st_in,
   output logic         st_out_valid,
   input  logic         st_out_ready,
   output logic [127:0] st_out,
   input  logic         kw_req_valid,
   output logic         kw_req_ready,
   input  logic [31:0]  kw_in,
   output logic         kw_out_valid,
   input  logic         kw_out_ready,
   output logic [31:0]  kw_out
);

   localparam int         ST_PASSES = STATE_BYTES / LANES;
   localparam int         KW_PASSES = WORD_BYTES / LANES;
   localparam logic [3:0] ST_LAST   = 4'(ST_PASSES - 1);
   localparam logic [3:0] KW_LAST   = 4'(KW_PASSES - 1);
   localparam int         LANE_SH   = (LANES == 4) ? 2 : (LANES == 2) ? 1 : 0;

   sched_state_e  state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ptr_kw_q, ptr_kw_d;
   logic [127:0]  data_q, data_d;
   logic          inv_q, inv_d;
   logic [127:0]  st_out_q, st_out_d;
   logic [31:0]   kw_out_q, kw_out_d;
   logic          st_vld_q, st_vld_d;
   logic          kw_vld_q, kw_vld_d;

   logic          idle_arb, st_grant, kw_grant;
   logic [3:0]    lane_base;
   logic [3:0]    lane_idx [LANES];
   logic [7:0]    lane_in  [LANES];
   logic [7:0]    lane_out [LANES];

   // Ready is only offered from IDLE and never while reset is asserted.
   assign idle_arb = !rst && (state_q == IDLE);
   assign st_grant = idle_arb && st_req_valid && (!kw_req_valid || !ptr_kw_q);
   assign kw_grant = idle_arb && kw_req_valid && (!st_req_valid || ptr_kw_q);

   assign st_req_ready = st_grant;
   assign kw_req_ready = kw_grant;
   assign st_out_valid = st_vld_q;
   assign kw_out_valid = kw_vld_q;
   assign st_out       = st_out_q;
   assign kw_out       = kw_out_q;

   assign lane_base = cnt_q << LANE_SH;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lane_idx[j] = lane_base + 4'(j);
      assign lane_in[j]  = data_q[{lane_idx[j], 3'b000} +: 8];
      sbox_lut u_lut (
         .din  (lane_in[j]),
         .inv  (inv_q),
         .dout (lane_out[j])
      );
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_kw_d = ptr_kw_q;
      data_d   = data_q;
      inv_d    = inv_q;
      st_out_d = st_out_q;
      kw_out_d = kw_out_q;
      st_vld_d = st_vld_q;
      kw_vld_d = kw_vld_q;
      case (state_q)
         IDLE: begin
            if (st_grant) begin
               data_d   = st_in;
               inv_d    = st_inv;
               cnt_d    = 4'd0;
               ptr_kw_d = 1'b1;
               state_d  = ST_BUSY;
            end else if (kw_grant) begin
               data_d   = {96'd0, kw_in};
               inv_d    = 1'b0;
               cnt_d    = 4'd0;
               ptr_kw_d = 1'b0;
               state_d  = KW_BUSY;
            end
         end
         ST_BUSY: begin
            for (int j = 0; j < LANES; j++) begin
               st_out_d[{lane_idx[j], 3'b000} +: 8] = lane_out[j];
            end
            if (cnt_q == ST_LAST) begin
               cnt_d    = 4'd0;
               st_vld_d = 1'b1;
               state_d  = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         KW_BUSY: begin
            for (int j = 0; j < LANES; j++) begin
               kw_out_d[{lane_idx[j][1:0], 3'b000} +: 8] = lane_out[j];
            end
            if (cnt_q == KW_LAST) begin
               cnt_d    = 4'd0;
               kw_vld_d = 1'b1;
               state_d  = KW_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (st_out_ready) begin
               st_vld_d = 1'b0;
               state_d  = IDLE;
            end
         end
         KW_DONE: begin
            if (kw_out_ready) begin
               kw_vld_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         ptr_kw_q <= 1'b1;
         data_q   <= '0;
         inv_q    <= 1'b0;
         st_out_q <= '0;
         kw_out_q <= '0;
         st_vld_q <= 1'b0;
         kw_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_kw_q <= ptr_kw_d;
         data_q   <= data_d;
         inv_q    <= inv_d;
         st_out_q <= st_out_d;
         kw_out_q <= kw_out_d;
         st_vld_q <= st_vld_d;
         kw_vld_q <= kw_vld_d;
      end
   end

endmodule

// File: tb/tb_sbox_sched.sv
// tb/tb_sbox_sched.sv - directed bench for sbox_sched at LANES 4, 1 and 2
module tb_sbox_sched;

   localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
   localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;
   localparam logic [127:0] ALL_63   = {16{8'h63}};

   logic         clk, rst;
   logic         st_req_valid [3];
   logic         st_req_ready [3];
   logic         st_inv       [3];
   logic [127:0] st_in        [3];
   logic         st_out_valid [3];
   logic         st_out_ready [3];
   logic [127:0] st_out       [3];
   logic         kw_req_valid [3];
   logic         kw_req_ready [3];
   logic [31:0]  kw_in        [3];
   logic         kw_out_valid [3];
   logic         kw_out_ready [3];
   logic [31:0]  kw_out       [3];

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit           is_kw;
      logic         inv;
      logic [127:0] din;
      logic [127:0] dout;
      string        name;
   } vec_t;

   vec_t vecs [8];
   int   lanes_of [3];

   sbox_sched #(.LANES(4)) u_l4 (
      .clk(clk), .rst(rst),
      .st_req_valid(st_req_valid[0]), .st_req_ready(st_req_ready[0]), .st_inv(st_inv[0]),
      .st_in(st_in[0]), .st_out_valid(st_out_valid[0]), .st_out_ready(st_out_ready[0]),
      .st_out(st_out[0]), .kw_req_valid(kw_req_valid[0]), .kw_req_ready(kw_req_ready[0]),
      .kw_in(kw_in[0]), .kw_out_valid(kw_out_valid[0]), .kw_out_ready(kw_out_ready[0]),
      .kw_out(kw_out[0])
   );

   sbox_sched #(.LANES(1)) u_l1 (
      .clk(clk), .rst(rst),
      .st_req_valid(st_req_valid[1]), .st_req_ready(st_req_ready[1]), .st_inv(st_inv[1]),
      .st_in(st_in[1]), .st_out_valid(st_out_valid[1]), .st_out_ready(st_out_ready[1]),
      .st_out(st_out[1]), .kw_req_valid(kw_req_valid[1]), .kw_req_ready(kw_req_ready[1]),
      .kw_in(kw_in[1]), .kw_out_valid(kw_out_valid[1]), .kw_out_ready(kw_out_ready[1]),
      .kw_out(kw_out[1])
   );

   sbox_sched #(.LANES(2)) u_l2 (
      .clk(clk), .rst(rst),
      .st_req_valid(st_req_valid[2]), .st_req_ready(st_req_ready[2]), .st_inv(st_inv[2]),
      .st_in(st_in[2]), .st_out_valid(st_out_valid[2]), .st_out_ready(st_out_ready[2]),
      .st_out(st_out[2]), .kw_req_valid(kw_req_valid[2]), .kw_req_ready(kw_req_ready[2]),
      .kw_in(kw_in[2]), .kw_out_valid(kw_out_valid[2]), .kw_out_ready(kw_out_ready[2]),
      .kw_out(kw_out[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a falling edge with the request already driven.
   task automatic wait_ready(input int k, input bit is_kw, input string name);
      int n;
      for (n = 0; n < 50; n++) begin
         #1;
         if (is_kw ? kw_req_ready[k] : st_req_ready[k]) break;
         @(negedge clk);
      end
      chk({name, " ready"}, 128'(n < 50), 128'd1);
   endtask

   // Called just after the accept edge; counts edges until the result is valid.
   task automatic wait_valid(input int k, input bit is_kw, output int n);
      n = 0;
      while (!(is_kw ? kw_out_valid[k] : st_out_valid[k]) && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_req(input int k, input bit is_kw, input logic inv, input logic [127:0] din,
                          input logic [127:0] dexp, input int lat, input string name);
      int n;
      @(negedge clk);
      if (is_kw) begin
         kw_in[k] = din[31:0];
         kw_req_valid[k] = 1'b1;
      end else begin
         st_in[k] = din;
         st_inv[k] = inv;
         st_req_valid[k] = 1'b1;
      end
      wait_ready(k, is_kw, name);
      @(posedge clk);
      #1;
      st_req_valid[k] = 1'b0;
      kw_req_valid[k] = 1'b0;
      st_in[k] = ~din;
      kw_in[k] = ~din[31:0];
      st_inv[k] = ~inv;
      wait_valid(k, is_kw, n);
      chk({name, " latency"}, 128'(n), 128'(lat));
      chk({name, " data"}, is_kw ? {96'd0, kw_out[k]} : st_out[k], dexp);
      if (is_kw) kw_out_ready[k] = 1'b1;
      else st_out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      kw_out_ready[k] = 1'b0;
      st_out_ready[k] = 1'b0;
      chk({name, " valid drop"}, 128'(is_kw ? kw_out_valid[k] : st_out_valid[k]), 128'd0);
      chk({name, " hold"}, is_kw ? {96'd0, kw_out[k]} : st_out[k], dexp);
   endtask

   initial begin
      int n, gr, bad_v, bad_d, bad_r, seen;
      logic [127:0] snap;

      lanes_of = '{4, 1, 2};
      vecs[0] = '{1'b0, 1'b0, 128'd0, ALL_63, "st zero fwd"};
      vecs[1] = '{1'b1, 1'b0, 128'hcf4f3c09, 128'h8a84eb01, "kw cf4f3c09"};
      vecs[2] = '{1'b0, 1'b1, ALL_63, 128'd0, "st 63 inv"};
      vecs[3] = '{1'b0, 1'b0, 128'h53, {{15{8'h63}}, 8'hed}, "st byte0 53"};
      vecs[4] = '{1'b0, 1'b0, FIPS_IN, FIPS_OUT, "st fips fwd"};
      vecs[5] = '{1'b0, 1'b1, FIPS_OUT, FIPS_IN, "st fips inv"};
      vecs[6] = '{1'b1, 1'b0, 128'hff100153, 128'h16ca7ced, "kw mixed"};
      vecs[7] = '{1'b0, 1'b0, {16{8'hff}}, {16{8'h16}}, "st all ff"};

      for (int k = 0; k < 3; k++) begin
         st_req_valid[k] = 1'b0; st_inv[k] = 1'b0; st_in[k] = '0; st_out_ready[k] = 1'b0;
         kw_req_valid[k] = 1'b0; kw_in[k] = '0; kw_out_ready[k] = 1'b0;
      end
      rst = 1'b1;
      st_req_valid[0] = 1'b1;
      kw_req_valid[0] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset st_req_ready", 128'(st_req_ready[0]), 128'd0);
      chk("reset kw_req_ready", 128'(kw_req_ready[0]), 128'd0);
      chk("reset st_out_valid", 128'(st_out_valid[0]), 128'd0);
      chk("reset kw_out_valid", 128'(kw_out_valid[0]), 128'd0);
      chk("reset st_out", st_out[0], 128'd0);
      chk("reset kw_out", 128'(kw_out[0]), 128'd0);

      // Both requesters held valid out of reset: grants alternate starting with kw.
      @(negedge clk);
      rst = 1'b0;
      st_out_ready[0] = 1'b1;
      kw_out_ready[0] = 1'b1;
      for (int g = 0; g < 4; g++) begin
         for (n = 0; n < 50; n++) begin
            #1;
            if (st_req_ready[0] || kw_req_ready[0]) break;
            @(negedge clk);
         end
         gr = {30'd0, st_req_ready[0], kw_req_ready[0]};
         chk($sformatf("grant %0d", g), 128'(gr), (g % 2 == 0) ? 128'd1 : 128'd2);
         @(posedge clk);
         if (g == 3) begin
            #1;
            st_req_valid[0] = 1'b0;
            kw_req_valid[0] = 1'b0;
         end
         @(negedge clk);
      end
      repeat (10) @(posedge clk);
      #1;
      chk("rr st result", st_out[0], ALL_63);
      chk("rr kw result", 128'(kw_out[0]), 128'h63636363);
      st_out_ready[0] = 1'b0;
      kw_out_ready[0] = 1'b0;

      for (int v = 0; v < 8; v++) begin
         run_req(0, vecs[v].is_kw, vecs[v].inv, vecs[v].din, vecs[v].dout,
                 vecs[v].is_kw ? 1 : 4, vecs[v].name);
      end
      chk("kw leaves st_out", st_out[0], {16{8'h16}});

      // Stalled state result blocks the kw requester until the handshake.
      @(negedge clk);
      st_in[0] = FIPS_IN;
      st_inv[0] = 1'b0;
      st_req_valid[0] = 1'b1;
      wait_ready(0, 1'b0, "stall st");
      @(posedge clk);
      #1;
      st_req_valid[0] = 1'b0;
      kw_in[0] = 32'hcf4f3c09;
      kw_req_valid[0] = 1'b1;
      wait_valid(0, 1'b0, n);
      chk("stall st latency", 128'(n), 128'd4);
      snap = st_out[0];
      chk("stall st data", snap, FIPS_OUT);
      bad_v = 0; bad_d = 0; bad_r = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (!st_out_valid[0]) bad_v++;
         if (st_out[0] !== snap) bad_d++;
         if (kw_req_ready[0]) bad_r++;
      end
      chk("stall valid held", 128'(bad_v), 128'd0);
      chk("stall data held", 128'(bad_d), 128'd0);
      chk("stall kw blocked", 128'(bad_r), 128'd0);
      st_out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      st_out_ready[0] = 1'b0;
      chk("stall st released", 128'(st_out_valid[0]), 128'd0);
      chk("stall kw ready after", 128'(kw_req_ready[0]), 128'd1);
      @(posedge clk);
      #1;
      kw_req_valid[0] = 1'b0;
      wait_valid(0, 1'b1, n);
      chk("stall kw latency", 128'(n), 128'd1);
      chk("stall kw data", 128'(kw_out[0]), 128'h8a84eb01);
      kw_out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      kw_out_ready[0] = 1'b0;

      // Reset during pass 2 of a state request, for each lane count.
      for (int k = 0; k < 3; k++) begin
         run_req(k, 1'b1, 1'b0, 128'hcf4f3c09, 128'h8a84eb01, 4 / lanes_of[k],
                 $sformatf("L%0d pre kw", lanes_of[k]));
         run_req(k, 1'b0, 1'b0, FIPS_IN, FIPS_OUT, 16 / lanes_of[k],
                 $sformatf("L%0d pre st", lanes_of[k]));
         @(negedge clk);
         st_in[k] = FIPS_IN;
         st_inv[k] = 1'b0;
         st_req_valid[k] = 1'b1;
         wait_ready(k, 1'b0, $sformatf("L%0d abort st", lanes_of[k]));
         @(posedge clk);
         #1;
         st_req_valid[k] = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         chk($sformatf("L%0d abort outs", lanes_of[k]),
             {st_out[k][125:0], st_out_valid[k], kw_out_valid[k]} | 128'(kw_out[k]), 128'd0);
         chk($sformatf("L%0d abort st_out", lanes_of[k]), st_out[k], 128'd0);
         seen = 0;
         repeat (20) begin
            @(posedge clk);
            #1;
            if (st_out_valid[k]) seen++;
         end
         chk($sformatf("L%0d abort no result", lanes_of[k]), 128'(seen), 128'd0);
         run_req(k, 1'b0, 1'b0, FIPS_IN, FIPS_OUT, 16 / lanes_of[k],
                 $sformatf("L%0d post st", lanes_of[k]));
         run_req(k, 1'b1, 1'b0, 128'hff100153, 128'h16ca7ced, 4 / lanes_of[k],
                 $sformatf("L%0d post kw", lanes_of[k]));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
